// File: rtl/gate_tester.sv
// Purpose : exhaustive tester for a 2-input gate; walks vectors 00,01,10,11 and compares the response against TRUTH.
// Latency : SETTLE+1 cycles per vector; done pulses 4*(SETTLE+1)+1 cycles after start is seen in IDLE.
// Backpres: none; start is only honoured in IDLE and ignored while a run is in progress or finishing.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset, overrides everything including a run in progress
//   start      - begin a run (sampled in IDLE only)
//   y_in       - response of the gate under test
//   a_out/b_out- registered gate inputs, {a_out,b_out} = current vector index
//   busy       - high in WAIT and SAMPLE
//   done       - one-cycle pulse at the end of a completed run
//   pass       - result of the last run, valid from the done cycle until the next start/reset
//   err_count  - number of mismatched vectors (0..4)
//   fail_vec   - bit i set iff vector i mismatched
module gate_tester #(
    parameter logic [3:0]  TRUTH  = 4'b0111,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter reload: WAIT runs from SETTLE-1 down to 0, i.e. SETTLE cycles.
    localparam logic [3:0] L_RELOAD = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fail;
    logic       w_mismatch;

    assign w_mismatch = (r_state == S_SAMPLE) && (y_in != TRUTH[r_vec]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_WAIT;
            S_WAIT:   if (r_cnt == 4'd0) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_vec == 2'd3) ? S_DONE : S_WAIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_WAIT,
            S_SAMPLE: busy = 1'b1;
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

    // Vector, settle counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec  <= 2'd0;
            r_cnt  <= 4'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 3'd0;
            r_fail <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec  <= 2'd0;
                        r_a    <= 1'b0;
                        r_b    <= 1'b0;
                        r_cnt  <= L_RELOAD;
                        r_err  <= 3'd0;
                        r_fail <= 4'd0;
                        r_pass <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err != 3'd4) r_err <= r_err + 3'd1;
                        r_fail[r_vec] <= 1'b1;
                    end
                    if (r_vec != 2'd3) begin
                        r_vec        <= r_vec + 2'd1;
                        {r_a, r_b}   <= r_vec + 2'd1;
                        r_cnt        <= L_RELOAD;
                    end else begin
                        // Last vector: fold its own compare in so pass is valid in the done cycle.
                        r_pass <= (r_err == 3'd0) && !w_mismatch;
                    end
                end
                S_DONE: begin
                    r_a <= 1'b0;
                    r_b <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_tester.sv
module tb_gate_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic sel;      // 0: SETTLE=2 instance, 1: SETTLE=1 instance
    int   mode;     // 0 NAND, 1 stuck-1, 2 stuck-0, 3 AND

    logic       start1, start2, y1, y2;
    logic       a1, b1, busy1, done1, pass1;
    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] err1, err2;
    logic [3:0] fail1, fail2;

    int checks = 0;
    int errors = 0;

    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            0:       return ~(a & b);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return a & b;
        endcase
    endfunction

    assign start1 = start & ~sel;
    assign start2 = start & sel;
    assign y1 = gate_model(mode, a1, b1);
    assign y2 = gate_model(mode, a2, b2);

    gate_tester #(.TRUTH(4'b0111), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    gate_tester #(.TRUTH(4'b0111), .SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start2), .y_in(y2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2)
    );

    // Views of the selected instance
    logic       va, vb, vbusy, vdone, vpass;
    logic [2:0] verr;
    logic [3:0] vfail;
    assign va    = sel ? a2    : a1;
    assign vb    = sel ? b2    : b1;
    assign vbusy = sel ? busy2 : busy1;
    assign vdone = sel ? done2 : done1;
    assign vpass = sel ? pass2 : pass1;
    assign verr  = sel ? err2  : err1;
    assign vfail = sel ? fail2 : fail1;

    // Observations from the last run
    int          done_cyc;
    int          done_n;
    logic [1:0]  obs_ab [4];
    logic [11:0] snap;          // {a,b,busy,done,pass,err[2:0],fail[3:0]}
    logic        pass_at_done;
    logic [2:0]  err_at_done;
    logic [3:0]  fail_at_done;

    // Called at a negedge (cycle 0). smask/rmask bit c = start/rst level in cycle c.
    task automatic run(input int settle, input int max_cyc, input logic [31:0] smask,
                       input logic [31:0] rmask, input int snap_c);
        done_cyc = -1;
        done_n   = 0;
        snap     = '0;
        pass_at_done = 1'b0;
        err_at_done  = '0;
        fail_at_done = '0;
        for (int v = 0; v < 4; v++) obs_ab[v] = 2'bxx;
        start = smask[0];
        rst   = rmask[0];
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (vdone) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    pass_at_done = vpass;
                    err_at_done  = verr;
                    fail_at_done = vfail;
                end
            end
            for (int v = 0; v < 4; v++)
                if (c == (v + 1) * (settle + 1)) obs_ab[v] = {va, vb};
            if (c == snap_c) snap = {va, vb, vbusy, vdone, vpass, verr, vfail};
            start = smask[c];
            rst   = rmask[c];
        end
    endtask

    task automatic test_reset;
        sel = 1'b0; mode = 0; start = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a1, b1, busy1, done1, pass1, err1, fail1} !== 12'h000) begin
            errors++;
            $display("FAIL reset_s2 got=%h exp=000", {a1, b1, busy1, done1, pass1, err1, fail1});
        end
        checks++;
        if ({a2, b2, busy2, done2, pass2, err2, fail2} !== 12'h000) begin
            errors++;
            $display("FAIL reset_s1 got=%h exp=000", {a2, b2, busy2, done2, pass2, err2, fail2});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nand;
        sel = 1'b0; mode = 0;
        run(2, 16, 32'h1, 32'h0, 0);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL nand_done_cycle got=%0d exp=13", done_cyc); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL nand_done_count got=%0d exp=1", done_n); end
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (obs_ab[v] !== 2'(v)) begin errors++; $display("FAIL nand_vec%0d got=%b exp=%b", v, obs_ab[v], 2'(v)); end
        end
        checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL nand_pass_at_done got=%b exp=1", pass_at_done); end
        checks++; if (vpass !== 1'b1) begin errors++; $display("FAIL nand_pass got=%b exp=1", vpass); end
        checks++; if (verr !== 3'd0) begin errors++; $display("FAIL nand_err got=%0d exp=0", verr); end
        checks++; if (vfail !== 4'b0000) begin errors++; $display("FAIL nand_fail got=%b exp=0000", vfail); end
        checks++; if ({va, vb, vbusy} !== 3'b000) begin errors++; $display("FAIL nand_idle_ab_busy got=%b exp=000", {va, vb, vbusy}); end
    endtask

    // Stuck-at-1 run; a start pulse in the DONE cycle must not launch a new run.
    task automatic test_stuck1;
        sel = 1'b0; mode = 1;
        run(2, 18, 32'h2001, 32'h0, 14);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL s1_done_cycle got=%0d exp=13", done_cyc); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL s1_done_count got=%0d exp=1", done_n); end
        checks++; if (verr !== 3'd1) begin errors++; $display("FAIL s1_err got=%0d exp=1", verr); end
        checks++; if (vfail !== 4'b1000) begin errors++; $display("FAIL s1_fail got=%b exp=1000", vfail); end
        checks++; if (vpass !== 1'b0) begin errors++; $display("FAIL s1_pass got=%b exp=0", vpass); end
        checks++; if (snap[9] !== 1'b0) begin errors++; $display("FAIL s1_start_in_done_busy got=%b exp=0", snap[9]); end
    endtask

    task automatic test_stuck0;
        sel = 1'b0; mode = 2;
        run(2, 16, 32'h1, 32'h0, 0);
        checks++; if (err_at_done !== 3'd3) begin errors++; $display("FAIL s0_err got=%0d exp=3", err_at_done); end
        checks++; if (fail_at_done !== 4'b0111) begin errors++; $display("FAIL s0_fail got=%b exp=0111", fail_at_done); end
        checks++; if (vpass !== 1'b0) begin errors++; $display("FAIL s0_pass got=%b exp=0", vpass); end
    endtask

    task automatic test_and;
        sel = 1'b0; mode = 3;
        run(2, 16, 32'h1, 32'h0, 0);
        checks++; if (verr !== 3'd4) begin errors++; $display("FAIL and_err got=%0d exp=4", verr); end
        checks++; if (vfail !== 4'b1111) begin errors++; $display("FAIL and_fail got=%b exp=1111", vfail); end
        checks++; if (vpass !== 1'b0) begin errors++; $display("FAIL and_pass got=%b exp=0", vpass); end
    endtask

    // start re-pulsed in WAIT of vector 2 (cycle 8), then again the cycle after done (14).
    task automatic test_back_to_back;
        sel = 1'b0; mode = 0;
        run(2, 15, 32'h4101, 32'h0, 15);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=13", done_cyc); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", done_n); end
        checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL b2b_pass_at_done got=%b exp=1", pass_at_done); end
        // Cycle 15: new run in WAIT, results cleared
        checks++; if (snap !== 12'h200) begin errors++; $display("FAIL b2b_restart_state got=%h exp=200", snap); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset during SAMPLE of vector 1 (cycle 6) aborts the run.
    task automatic test_abort;
        sel = 1'b0; mode = 2;
        run(2, 20, 32'h1, 32'h40, 7);
        checks++; if (snap !== 12'h000) begin errors++; $display("FAIL abort_outputs got=%h exp=000", snap); end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL abort_done_count got=%0d exp=0", done_n); end
        mode = 0;
        run(2, 16, 32'h1, 32'h0, 0);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL abort_rerun_done got=%0d exp=13", done_cyc); end
        checks++; if ({vpass, verr, vfail} !== 8'h80) begin errors++; $display("FAIL abort_rerun_result got=%h exp=80", {vpass, verr, vfail}); end
    endtask

    task automatic test_settle1;
        sel = 1'b1; mode = 0;
        run(1, 12, 32'h1, 32'h0, 0);
        checks++; if (done_cyc !== 9) begin errors++; $display("FAIL st1_done_cycle got=%0d exp=9", done_cyc); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL st1_done_count got=%0d exp=1", done_n); end
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (obs_ab[v] !== 2'(v)) begin errors++; $display("FAIL st1_vec%0d got=%b exp=%b", v, obs_ab[v], 2'(v)); end
        end
        checks++; if ({vpass, verr, vfail} !== 8'h80) begin errors++; $display("FAIL st1_result got=%h exp=80", {vpass, verr, vfail}); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL st1_other_idle got=%b exp=0", busy1); end
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; mode = 0;
        @(negedge clk);
        test_reset();
        test_nand();
        test_stuck1();
        test_stuck0();
        test_and();
        test_back_to_back();
        test_abort();
        test_settle1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
